// File: rtl/memwb.sv
// Memory-access / write-back stage: runs one instruction at a time, drives the
// data bus for loads/stores and returns the register-file write port.
//
// state  | meaning
// S_IDLE | empty, can accept
// S_BUS  | bus request outstanding, waiting for ack
// S_WB   | register write-back this cycle, can accept the next instruction
// S_EXC  | one-cycle memory exception pulse, not accepting
module memwb #(
  parameter int RW    = 16,
  parameter int REGNO = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_submit,
  output logic             o_ready,
  input  logic [RW-1:0]    i_data,
  input  logic [RW-1:0]    i_addr,
  input  logic [REGNO-1:0] i_reg_ie,
  input  logic             i_mem_access,
  input  logic             i_mem_we,
  input  logic             i_mem_width,
  output logic [REGNO-1:0] o_reg_ie,
  output logic [RW-1:0]    o_reg_data,
  output logic             o_mem_exception,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [RW-2:0]    o_mem_addr,
  output logic [1:0]       o_mem_sel,
  output logic [RW-1:0]    o_mem_data,
  input  logic             i_mem_ack,
  input  logic             i_mem_err,
  input  logic [RW-1:0]    i_mem_data
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_WB, S_EXC} state_t;

  state_t           state;
  logic [REGNO-1:0] r_ie;
  logic             r_we;
  logic             r_width;
  logic             r_lsb;
  logic [7:0]       lane;

  assign o_ready = i_rst_n & ((state == S_IDLE) | (state == S_WB));
  assign lane    = r_lsb ? i_mem_data[15:8] : i_mem_data[7:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state           <= S_IDLE;
      r_ie            <= '0;
      r_we            <= 1'b0;
      r_width         <= 1'b0;
      r_lsb           <= 1'b0;
      o_reg_ie        <= '0;
      o_reg_data      <= '0;
      o_mem_exception <= 1'b0;
      o_mem_req       <= 1'b0;
      o_mem_we        <= 1'b0;
      o_mem_addr      <= '0;
      o_mem_sel       <= 2'b00;
      o_mem_data      <= '0;
    end else begin
      o_reg_ie        <= '0;
      o_mem_exception <= 1'b0;
      case (state)
        S_IDLE, S_WB: begin
          if (i_submit) begin
            if (!i_mem_access) begin
              state      <= S_WB;
              o_reg_ie   <= i_reg_ie;
              o_reg_data <= i_data;
            end else if (!i_mem_width && i_addr[0]) begin
              state           <= S_EXC;
              o_mem_exception <= 1'b1;
            end else begin
              state      <= S_BUS;
              r_ie       <= i_reg_ie;
              r_we       <= i_mem_we;
              r_width    <= i_mem_width;
              r_lsb      <= i_addr[0];
              o_mem_req  <= 1'b1;
              o_mem_we   <= i_mem_we;
              o_mem_addr <= i_addr[RW-1:1];
              o_mem_sel  <= i_mem_width ? (i_addr[0] ? 2'b10 : 2'b01) : 2'b11;
              o_mem_data <= i_mem_width ? {(RW/8){i_data[7:0]}} : i_data;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_BUS: begin
          if (i_mem_ack) begin
            o_mem_req <= 1'b0;
            o_mem_we  <= 1'b0;
            if (i_mem_err) begin
              state           <= S_EXC;
              o_mem_exception <= 1'b1;
            end else begin
              state    <= S_WB;
              o_reg_ie <= r_we ? '0 : r_ie;
              // Stores leave the last write-back data untouched; ie is 0 anyway.
              if (!r_we)
                o_reg_data <= r_width ? {{(RW-8){1'b0}}, lane} : i_mem_data;
            end
          end
        end
        S_EXC: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memwb.sv
// Self-checking bench for memwb: directed cases plus randomized instructions
// checked against a transaction-level model of the stage.
module tb_memwb;
  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_submit = 1'b0;
  logic        o_ready;
  logic [15:0] i_data = '0;
  logic [15:0] i_addr = '0;
  logic [7:0]  i_reg_ie = '0;
  logic        i_mem_access = 1'b0;
  logic        i_mem_we = 1'b0;
  logic        i_mem_width = 1'b0;
  logic [7:0]  o_reg_ie;
  logic [15:0] o_reg_data;
  logic        o_mem_exception;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [14:0] o_mem_addr;
  logic [1:0]  o_mem_sel;
  logic [15:0] o_mem_data;
  logic        i_mem_ack = 1'b0;
  logic        i_mem_err = 1'b0;
  logic [15:0] i_mem_data = '0;

  int n_vec = 0;
  int n_err = 0;

  memwb #(.RW(16), .REGNO(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_submit(i_submit), .o_ready(o_ready),
    .i_data(i_data), .i_addr(i_addr), .i_reg_ie(i_reg_ie),
    .i_mem_access(i_mem_access), .i_mem_we(i_mem_we), .i_mem_width(i_mem_width),
    .o_reg_ie(o_reg_ie), .o_reg_data(o_reg_data), .o_mem_exception(o_mem_exception),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_sel(o_mem_sel), .o_mem_data(o_mem_data),
    .i_mem_ack(i_mem_ack), .i_mem_err(i_mem_err), .i_mem_data(i_mem_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_sel(input logic byte_w, input logic [15:0] a);
    if (!byte_w) return 2'b11;
    return (a % 2 == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [15:0] exp_wdata(input logic byte_w, input logic [15:0] d);
    if (!byte_w) return d;
    return (d % 256) * 257;
  endfunction

  function automatic logic [15:0] exp_load(input logic byte_w, input logic [15:0] a,
                                           input logic [15:0] md);
    if (!byte_w) return md;
    return (a % 2 == 1) ? (md / 256) : (md % 256);
  endfunction

  // Offer an instruction during EXC and confirm it is dropped.
  task automatic poke_during_exc();
    i_submit = 1'b1; i_mem_access = 1'b0; i_reg_ie = 8'hFF; i_data = 16'hDEAD;
    chk("exc_ready", o_ready, 0);
    @(negedge i_clk);
    i_submit = 1'b0;
    chk("exc_pulse_len", o_mem_exception, 0);
    chk("exc_no_accept_ie", o_reg_ie, 0);
    chk("exc_no_req", o_mem_req, 0);
  endtask

  task automatic do_instr(input logic acc, input logic we, input logic byte_w,
                          input logic [15:0] d, input logic [15:0] a, input logic [7:0] ie,
                          input int wait_n, input logic err, input logic [15:0] md);
    int guard = 0;
    while (!o_ready) begin
      @(negedge i_clk);
      guard++;
      if (guard > 50) begin
        chk("ready_timeout", 0, 1);
        return;
      end
    end
    i_submit = 1'b1; i_mem_access = acc; i_mem_we = we; i_mem_width = byte_w;
    i_data = d; i_addr = a; i_reg_ie = ie;
    @(negedge i_clk);
    i_submit = 1'b0;
    if (!acc) begin
      chk("alu_ie", o_reg_ie, ie);
      chk("alu_data", o_reg_data, d);
      chk("alu_ready", o_ready, 1);
      chk("alu_no_req", o_mem_req, 0);
    end else if (!byte_w && a[0]) begin
      chk("mis_exc", o_mem_exception, 1);
      chk("mis_no_req", o_mem_req, 0);
      chk("mis_ie", o_reg_ie, 0);
      poke_during_exc();
    end else begin
      chk("bus_req", o_mem_req, 1);
      chk("bus_we", o_mem_we, we);
      chk("bus_addr", o_mem_addr, a / 2);
      chk("bus_sel", o_mem_sel, exp_sel(byte_w, a));
      if (we) chk("bus_wdata", o_mem_data, exp_wdata(byte_w, d));
      chk("bus_ready", o_ready, 0);
      for (int i = 0; i < wait_n; i++) begin
        @(negedge i_clk);
        chk("hold_req", o_mem_req, 1);
        chk("hold_addr", o_mem_addr, a / 2);
        chk("hold_sel", o_mem_sel, exp_sel(byte_w, a));
        chk("hold_ready", o_ready, 0);
      end
      i_mem_ack = 1'b1; i_mem_err = err; i_mem_data = md;
      @(negedge i_clk);
      i_mem_ack = 1'b0; i_mem_err = 1'b0;
      chk("post_ack_req", o_mem_req, 0);
      if (err) begin
        chk("err_exc", o_mem_exception, 1);
        chk("err_ie", o_reg_ie, 0);
        poke_during_exc();
      end else begin
        chk("wb_exc", o_mem_exception, 0);
        chk("wb_ie", o_reg_ie, we ? 8'h00 : ie);
        if (!we) chk("wb_data", o_reg_data, exp_load(byte_w, a, md));
        chk("wb_ready", o_ready, 1);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ie"}, o_reg_ie, 0);
    chk({tag, "_data"}, o_reg_data, 0);
    chk({tag, "_exc"}, o_mem_exception, 0);
    chk({tag, "_req"}, o_mem_req, 0);
    chk({tag, "_we"}, o_mem_we, 0);
    chk({tag, "_addr"}, o_mem_addr, 0);
    chk({tag, "_sel"}, o_mem_sel, 0);
    chk({tag, "_wdata"}, o_mem_data, 0);
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    chk_all_zero("rst");
    chk("rst_ready", o_ready, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("idle_ready", o_ready, 1);

    // ALU then three back-to-back ALU ops
    do_instr(0, 0, 0, 16'h1234, 16'h0000, 8'b0000_0100, 0, 0, 0);
    do_instr(0, 0, 0, 16'h1111, 16'h0000, 8'h01, 0, 0, 0);
    do_instr(0, 0, 0, 16'h2222, 16'h0000, 8'h02, 0, 0, 0);
    do_instr(0, 0, 0, 16'h3333, 16'h0000, 8'h80, 0, 0, 0);
    // word load, three wait cycles
    do_instr(1, 0, 0, 16'h0000, 16'h0010, 8'h08, 3, 0, 16'hBEEF);
    // byte load high lane, byte store low lane
    do_instr(1, 0, 1, 16'h0000, 16'h0021, 8'h10, 0, 0, 16'hA55A);
    do_instr(1, 1, 1, 16'h00C3, 16'h0020, 8'h20, 1, 0, 16'h0000);
    // misaligned word access
    do_instr(1, 0, 0, 16'h0000, 16'h0003, 8'h40, 0, 0, 0);
    // bus error on load
    do_instr(1, 0, 0, 16'h0000, 16'h0044, 8'h02, 2, 1, 16'h5555);

    // reset in the middle of a bus cycle
    @(negedge i_clk);
    i_submit = 1'b1; i_mem_access = 1'b1; i_mem_we = 1'b0; i_mem_width = 1'b0;
    i_addr = 16'h0100; i_reg_ie = 8'h04;
    @(negedge i_clk);
    i_submit = 1'b0;
    chk("mid_bus_req", o_mem_req, 1);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk_all_zero("midrst");
    chk("midrst_ready", o_ready, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    i_mem_ack = 1'b1; i_mem_data = 16'hFFFF;
    @(negedge i_clk);
    i_mem_ack = 1'b0;
    chk("stray_ack_ie", o_reg_ie, 0);
    chk("stray_ack_exc", o_mem_exception, 0);
    do_instr(0, 0, 0, 16'h4321, 16'h0000, 8'h01, 0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      logic        acc, we, bw, err;
      logic [15:0] d, a, md;
      logic [7:0]  ie;
      int          w;
      acc = ($urandom_range(0, 2) != 0);
      we  = 1'($urandom_range(0, 1));
      bw  = 1'($urandom_range(0, 1));
      err = ($urandom_range(0, 7) == 0);
      d   = 16'($urandom);
      a   = 16'($urandom);
      md  = 16'($urandom);
      ie  = 8'(1 << $urandom_range(0, 7));
      w   = $urandom_range(0, 3);
      do_instr(acc, we, bw, d, a, ie, w, err, md);
    end

    repeat (2) @(negedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
